// File: rtl/sc_tx_pkg.sv
// Shared constants and types for the slow-control TX arbiter.
// Field widths, channel limit, one-hot FSM encoding and pointer wrap helper.
package sc_tx_pkg;

    localparam int DATA_W  = 8;
    localparam int PORT_W  = 16;
    localparam int IP_W    = 32;
    localparam int ERR_W   = 8;
    localparam int MAX_NCH = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_GRANT   = 3'b010,
        ST_RELEASE = 3'b100
    } state_e;

    // Advance a channel index by one, wrapping back to 0 after the last channel.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int nch);
        logic [IDX_W-1:0] nxt;
        if (int'(idx) + 1 >= nch) begin
            nxt = '0;
        end else begin
            nxt = idx + 1'b1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// Combinational picker: first requesting channel at or after ptr (rr=1, wrapping)
// or lowest requesting index (rr=0). Returns one-hot grant, its index and a valid flag.
module sc_rr_pick
    import sc_tx_pkg::*;
#(
    parameter int NCH = 3
) (
    input  logic [NCH-1:0]   req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr,
    output logic [NCH-1:0]   grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    // Walk the candidates in priority order k = 0..NCH-1; the first requester found wins.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            for (int j = 0; j < NCH; j++) begin
                if (!grant_vld && req[j] && ((((rr ? int'(ptr) : 0) + k) % NCH) == j)) begin
                    grant_vld   = 1'b1;
                    grant_oh[j] = 1'b1;
                    grant_idx   = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/sc_tx_arbiter.sv
// N-channel arbiter in front of the UDP TX engine: grant held until ch_done, fields muxed.
// Optional grant watchdog compiled in with `define SC_TX_ARB_WATCHDOG_EN.
module sc_tx_arbiter
    import sc_tx_pkg::*;
#(
    parameter int NCH     = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_rr,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_start,
    input  logic [NCH-1:0]        ch_done,
    input  logic [DATA_W*NCH-1:0] ch_data,
    input  logic [PORT_W*NCH-1:0] ch_srcport,
    input  logic [PORT_W*NCH-1:0] ch_dstport,
    input  logic [PORT_W*NCH-1:0] ch_length,
    input  logic [IP_W*NCH-1:0]   ch_dstip,
    output logic [NCH-1:0]        ch_ack,
    output logic                  tx_req,
    input  logic                  tx_ack,
    output logic                  tx_start,
    output logic                  tx_done,
    output logic [DATA_W-1:0]     tx_data,
    output logic [PORT_W-1:0]     tx_srcport,
    output logic [PORT_W-1:0]     tx_dstport,
    output logic [PORT_W-1:0]     tx_length,
    output logic [IP_W-1:0]       tx_dstip,
    output logic                  tx_abort,
    output logic [ERR_W-1:0]      err_cnt
);

    if (NCH < 1 || NCH > MAX_NCH || TIMEOUT < 1) begin : g_cfg_check
        $error("sc_tx_arbiter: NCH must be 1..8 and TIMEOUT at least 1");
    end

    state_e           state_q, state_d;
    logic [NCH-1:0]   ack_q, ack_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic [NCH-1:0]   pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    logic             granted;
    logic             cur_done;
    logic             wd_hit;
    logic [NCH-1:0]   sel_oh;

    sc_rr_pick #(
        .NCH (NCH)
    ) u_pick (
        .req       (ch_req),
        .ptr       (ptr_q),
        .rr        (cfg_rr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    assign granted  = (state_q == ST_GRANT);
    assign cur_done = |(ch_done & ack_q);
    assign tx_req   = |ch_req;
    assign ch_ack   = granted ? ack_q : '0;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_ack && pick_vld) begin
                    state_d = ST_GRANT;
                    ack_d   = pick_oh;
                    if (cfg_rr) begin
                        ptr_d = wrap_inc(pick_idx, NCH);
                    end
                end
            end
            ST_GRANT: begin
                if (cur_done || wd_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ack_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outside a grant the engine sees channel 0's fields with start low and done high.
    always_comb begin
        sel_oh     = granted ? ack_q : NCH'(1);
        tx_data    = ch_data[DATA_W-1:0];
        tx_srcport = ch_srcport[PORT_W-1:0];
        tx_dstport = ch_dstport[PORT_W-1:0];
        tx_length  = ch_length[PORT_W-1:0];
        tx_dstip   = ch_dstip[IP_W-1:0];
        for (int j = 0; j < NCH; j++) begin
            if (sel_oh[j]) begin
                tx_data    = ch_data[j*DATA_W +: DATA_W];
                tx_srcport = ch_srcport[j*PORT_W +: PORT_W];
                tx_dstport = ch_dstport[j*PORT_W +: PORT_W];
                tx_length  = ch_length[j*PORT_W +: PORT_W];
                tx_dstip   = ch_dstip[j*IP_W +: IP_W];
            end
        end
        tx_start = granted & |(ch_start & ack_q);
        tx_done  = granted ? cur_done : 1'b1;
    end

`ifdef SC_TX_ARB_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0]  wd_q, wd_d;
    logic             abort_q, abort_d;
    logic [ERR_W-1:0] err_q, err_d;

    assign wd_hit = (wd_q == WD_W'(TIMEOUT - 1));

    // Counter sits at 0 outside GRANT; a done arriving on the limit cycle takes priority.
    always_comb begin
        wd_d    = '0;
        abort_d = 1'b0;
        err_d   = err_q;
        if (granted) begin
            wd_d = wd_q + 1'b1;
            if (wd_hit && !cur_done) begin
                abort_d = 1'b1;
                if (err_q != {ERR_W{1'b1}}) begin
                    err_d = err_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_q    <= '0;
            abort_q <= 1'b0;
            err_q   <= '0;
        end else begin
            wd_q    <= wd_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    assign tx_abort = abort_q;
    assign err_cnt  = err_q;
`else
    assign wd_hit   = 1'b0;
    assign tx_abort = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_sc_tx_arbiter.sv
// Randomized scoreboard bench for sc_tx_arbiter (NCH=3) against a per-cycle behavioural model.
// Grants are queued by the stimulus side at decision time and popped by the monitor on each new ch_ack.
module tb_sc_tx_arbiter;

    localparam int NCH        = 3;
    localparam int TB_TIMEOUT = 16;

    logic                clk;
    logic                rstn;
    logic                cfg_rr;
    logic [NCH-1:0]      ch_req, ch_start, ch_done, ch_ack;
    logic [8*NCH-1:0]    ch_data;
    logic [16*NCH-1:0]   ch_srcport, ch_dstport, ch_length;
    logic [32*NCH-1:0]   ch_dstip;
    logic                tx_req, tx_ack, tx_start, tx_done, tx_abort;
    logic [7:0]          tx_data, err_cnt;
    logic [15:0]         tx_srcport, tx_dstport, tx_length;
    logic [31:0]         tx_dstip;

    int checks = 0;
    int errors = 0;

    int exp_q[$];
    int m_owner, last_owner, m_ptr, m_wd, m_err, own_cnt;
    bit m_release, m_abort;

    sc_tx_arbiter #(
        .NCH     (NCH),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_rr     (cfg_rr),
        .ch_req     (ch_req),
        .ch_start   (ch_start),
        .ch_done    (ch_done),
        .ch_data    (ch_data),
        .ch_srcport (ch_srcport),
        .ch_dstport (ch_dstport),
        .ch_length  (ch_length),
        .ch_dstip   (ch_dstip),
        .ch_ack     (ch_ack),
        .tx_req     (tx_req),
        .tx_ack     (tx_ack),
        .tx_start   (tx_start),
        .tx_done    (tx_done),
        .tx_data    (tx_data),
        .tx_srcport (tx_srcport),
        .tx_dstport (tx_dstport),
        .tx_length  (tx_length),
        .tx_dstip   (tx_dstip),
        .tx_abort   (tx_abort),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic int pickWinner(input logic [NCH-1:0] req, input bit rr, input int ptr);
        int c;
        for (int k = 0; k < NCH; k++) begin
            c = rr ? (ptr + k) % NCH : k;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic modelReset();
        m_owner    = -1;
        last_owner = 0;
        m_release  = 1'b0;
        m_ptr      = 0;
        m_wd       = 0;
        m_err      = 0;
        m_abort    = 1'b0;
        own_cnt    = 0;
        exp_q.delete();
    endtask

    // One clock edge of the reference: who owns the TX port for the coming cycle.
    task automatic modelStep();
        int g;
        m_abort = 1'b0;
        if (m_owner >= 0) begin
            if (ch_done[m_owner]) begin
                last_owner = m_owner;
                m_owner    = -1;
                m_release  = 1'b1;
            end
`ifdef SC_TX_ARB_WATCHDOG_EN
            else begin
                m_wd++;
                if (m_wd == TB_TIMEOUT) begin
                    last_owner = m_owner;
                    m_owner    = -1;
                    m_release  = 1'b1;
                    m_abort    = 1'b1;
                    if (m_err < 255) m_err++;
                end
            end
`endif
        end else if (m_release) begin
            m_release = 1'b0;
        end else if (tx_ack && (ch_req != '0)) begin
            g       = pickWinner(ch_req, cfg_rr, m_ptr);
            m_owner = g;
            m_wd    = 0;
            if (cfg_rr) m_ptr = (g + 1) % NCH;
            exp_q.push_back(g);
        end
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] req, input logic ack, input logic [NCH-1:0] done);
        ch_req   = req;
        tx_ack   = ack;
        ch_done  = done;
        ch_start = NCH'($urandom);
        for (int c = 0; c < NCH; c++) begin
            ch_data[c*8 +: 8]     = 8'($urandom);
            ch_srcport[c*16 +: 16] = 16'($urandom);
            ch_dstport[c*16 +: 16] = 16'($urandom);
            ch_length[c*16 +: 16]  = 16'($urandom);
            ch_dstip[c*32 +: 32]   = $urandom;
        end
    endtask

    // Channel agents: owner asserts done after frame_len grant cycles (0 = never) and
    // drops its request during RELEASE; others request/withdraw at random within mask.
    task automatic runCycles(input int n, input logic [NCH-1:0] mask, input int frame_len,
                             input bit keep_req, input bit noise, input int req_pct,
                             input int drop_pct, input int ack_pct);
        logic [NCH-1:0] req, done;
        logic           ack;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelStep();
            #1;
            req  = ch_req;
            done = '0;
            if (m_owner >= 0) begin
                own_cnt++;
                if (frame_len > 0 && own_cnt >= frame_len) done[m_owner] = 1'b1;
            end else begin
                own_cnt = 0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (c == m_owner) req[c] = 1'b1;
                else if (!mask[c]) req[c] = 1'b0;
                else if (keep_req) req[c] = 1'b1;
                else if (m_release && c == last_owner) req[c] = 1'b0;
                else if (!req[c]) req[c] = ($urandom_range(99) < req_pct);
                else if ($urandom_range(99) < drop_pct) req[c] = 1'b0;
                if (noise && c != m_owner && $urandom_range(3) == 0) done[c] = 1'b1;
            end
            ack = ($urandom_range(99) < ack_pct);
            applyStimulus(req, ack, done);
        end
    endtask

    initial begin
        logic [NCH-1:0] prev_ack;
        int             sel, g;
        prev_ack = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_ack = '0;
            end else begin
                sel = (m_owner >= 0) ? m_owner : 0;
                if (ch_ack != '0 && prev_ack == '0) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("grant_unexpected", ch_ack, 0);
                    end else begin
                        g = exp_q.pop_front();
                        checkOutput("grant_order", ch_ack, 64'(1) << g);
                    end
                end
                checkOutput("ch_ack", ch_ack, (m_owner >= 0) ? (64'(1) << m_owner) : 64'(0));
                checkOutput("tx_req", tx_req, |ch_req);
                checkOutput("tx_start", tx_start, (m_owner >= 0) ? ch_start[m_owner] : 1'b0);
                checkOutput("tx_done", tx_done, (m_owner >= 0) ? ch_done[m_owner] : 1'b1);
                checkOutput("tx_data", tx_data, ch_data[sel*8 +: 8]);
                checkOutput("tx_srcport", tx_srcport, ch_srcport[sel*16 +: 16]);
                checkOutput("tx_dstport", tx_dstport, ch_dstport[sel*16 +: 16]);
                checkOutput("tx_length", tx_length, ch_length[sel*16 +: 16]);
                checkOutput("tx_dstip", tx_dstip, ch_dstip[sel*32 +: 32]);
                checkOutput("tx_abort", tx_abort, m_abort);
                checkOutput("err_cnt", err_cnt, m_err);
                prev_ack = ch_ack;
            end
        end
    end

    initial begin
        rstn   = 1'b0;
        cfg_rr = 1'b0;
        modelReset();
        applyStimulus('0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ch_ack", ch_ack, 0);
        checkOutput("reset_tx_start", tx_start, 0);
        checkOutput("reset_tx_done", tx_done, 1);
        checkOutput("reset_tx_abort", tx_abort, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);
        checkOutput("reset_tx_dstip", tx_dstip, ch_dstip[31:0]);
        @(posedge clk);
        #1 rstn = 1'b1;

        $display("[TB] fixed priority, channels 1 and 2 requesting");
        applyStimulus(3'b110, 1'b1, '0);
        runCycles(14, 3'b110, 3, 1'b0, 1'b0, 0, 0, 100);
        runCycles(8, 3'b000, 1, 1'b0, 1'b0, 0, 0, 100);

        $display("[TB] round-robin, all channels requesting continuously");
        cfg_rr = 1'b1;
        runCycles(26, 3'b111, 4, 1'b1, 1'b0, 100, 0, 100);
        runCycles(8, 3'b000, 1, 1'b0, 1'b0, 0, 0, 100);

        $display("[TB] engine not ready");
        cfg_rr = 1'b0;
        runCycles(10, 3'b001, 4, 1'b1, 1'b0, 100, 0, 0);

        $display("[TB] foreign done pulses during grant");
        runCycles(16, 3'b001, 6, 1'b1, 1'b1, 100, 0, 100);
        runCycles(8, 3'b000, 1, 1'b0, 1'b0, 0, 0, 100);

        $display("[TB] randomized traffic");
        for (int r = 0; r < 6; r++) begin
            cfg_rr = r[0];
            runCycles(400, 3'b111, 1 + r, 1'b0, 1'b1, 30, 5, 80);
        end
        runCycles(10, 3'b000, 1, 1'b0, 1'b0, 0, 0, 100);

`ifdef SC_TX_ARB_WATCHDOG_EN
        $display("[TB] watchdog aborts");
        runCycles(5500, 3'b001, 0, 1'b1, 1'b0, 100, 0, 100);
        runCycles(20, 3'b000, 1, 1'b0, 1'b0, 0, 0, 100);
`endif

        $display("[TB] reset during grant");
        cfg_rr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            runCycles(1, 3'b110, 0, 1'b1, 1'b0, 100, 0, 100);
            if (ch_ack != '0) break;
        end
        checkOutput("grant_before_reset", (ch_ack != '0), 1);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_reset_ch_ack", ch_ack, 0);
        checkOutput("async_reset_tx_done", tx_done, 1);
        checkOutput("async_reset_tx_abort", tx_abort, 0);
        modelReset();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        applyStimulus(3'b111, 1'b1, '0);
        runCycles(20, 3'b111, 3, 1'b1, 1'b0, 100, 0, 100);
        runCycles(10, 3'b000, 1, 1'b0, 1'b0, 0, 0, 100);

        checkOutput("grants_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sc_tx_arbiter.md
# sc_tx_arbiter

Parametrised N-channel arbiter between slow-control reply/error sources and the single UDP TX engine port. Grants one requester at a time, holds the grant until that requester signals done, and steers its header fields and byte stream to the TX engine. Supports fixed-priority or round-robin selection, plus an optional grant watchdog. Replaces the hard-wired three-source arbiter inside the slow-control controller.

## Interface
- NCH, 3, number of requesting channels (1..8)
- TIMEOUT, 65535, watchdog limit in clk cycles (used only with watchdog compiled in)
- clk  in  1  TX-side clock (clk125 domain)
- rstn  in  1  asynchronous, active-low reset
- cfg_rr  in  1  0 = fixed priority (lowest index wins), 1 = round-robin
- ch_req  in  NCH  per-channel transmit request
- ch_start, ch_done  in  NCH  per-channel start strobe / frame-complete
- ch_data  in  8*NCH  per-channel payload byte
- ch_srcport, ch_dstport, ch_length  in  16*NCH  per-channel UDP fields
- ch_dstip  in  32*NCH  per-channel destination IP
- ch_ack  out  NCH  one-hot grant to channel
- tx_req  out  1  OR of all ch_req
- tx_ack  in  1  TX engine ready to accept a new frame
- tx_start, tx_done  out  1  muxed start / done
- tx_data  out  8; tx_srcport, tx_dstport, tx_length  out  16; tx_dstip  out  32  muxed fields
- tx_abort  out  1  one-cycle pulse on watchdog abort
- err_cnt  out  8  saturating abort count

## Operation
- States: IDLE, GRANT, RELEASE (one-hot, invalid encoding recovers to IDLE).
- IDLE: if tx_ack and any ch_req, pick winner g, register grant, go GRANT. Else stay.
- Fixed mode: g = lowest set index. RR mode: g = first set index at or after pointer ptr, wrapping NCH-1 -> 0; on grant ptr <= (g+1) mod NCH.
- GRANT: ch_ack[g]=1; all tx_* fields, tx_start, tx_done follow channel g combinationally. On ch_done[g] go RELEASE. ch_done on other channels ignored.
- RELEASE: one cycle, ch_ack all 0, lets the finished channel drop ch_req; then IDLE.
- Not granted (IDLE/RELEASE): tx_* fields show channel 0, tx_start=0, tx_done=1.
- Request dropped before grant: no grant issued; request reasserted later is re-arbitrated.
- cfg_rr change takes effect at the next IDLE decision; ptr kept.
- NCH=1: ptr fixed 0, both modes identical.

## Timing
- Reset values: state IDLE, ch_ack 0, ptr 0, tx_start 0, tx_done 1, tx_abort 0, err_cnt 0, fields = channel 0 inputs.
- Grant latency: tx_ack&req sampled at edge n -> ch_ack high from cycle n+1.
- ch_done[g] high at edge m -> ch_ack low from m+1, earliest next grant at m+2.
- tx_req purely combinational, zero latency.
- Reset mid-frame: grant dropped immediately (async), no tx_abort pulse.

## Configuration
- SC_TX_ARB_WATCHDOG_EN defined: counter clears on entry to GRANT, increments each GRANT cycle; when it reaches TIMEOUT without ch_done[g], go RELEASE, pulse tx_abort for one cycle, err_cnt += 1 saturating at 255. ch_done[g] in the same cycle as the limit wins: normal release, no abort.
- Undefined: no counter, grant held indefinitely, tx_abort and err_cnt tied 0.

## Structure
- Package sc_tx_pkg: state encoding constants, field widths (DATA_W 8, PORT_W 16, IP_W 32), max NCH.
- Sub-module sc_rr_pick: combinational rotate-priority picker (req, ptr, rr) -> one-hot + index.
- Top holds FSM, ptr, watchdog, output muxes.

## Test plan
- NCH=3, fixed, ch_req=3'b110, tx_ack=1 -> ch_ack=3'b010 next cycle, tx_dstip = channel 1 IP; ch_done[1] -> ch_ack 0 one cycle later, then ch 2 granted.
- RR, all three requesting continuously, each done after 4 cycles -> grant order 0,1,2,0,1 with one-cycle RELEASE gaps.
- tx_ack=0 with ch_req=3'b001 for 10 cycles -> no grant, tx_req=1, tx_done=1.
- ch_done[2] pulsed while channel 0 granted -> ignored, grant stays on 0.
- Watchdog build, TIMEOUT=16, no done -> RELEASE at GRANT cycle 16, tx_abort one pulse, err_cnt=1; 300 aborts -> err_cnt=255.
- rstn low during GRANT -> ch_ack 0 immediately, ptr 0, first grant after release from fixed/RR start at 0.
